// File: rtl/memu_bus_if.sv
// memu_bus_if: req/gnt/rvalid data bus between the memory stage and memory.
interface memu_bus_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/memu_bus.sv
// memu_bus: RV32I load/store stage over a variable-latency req/gnt/rvalid bus.
module memu_bus #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exmem2mem_valid_i,
    input  logic              exmem2mem_wb_en_i,
    input  logic [6:0]        exmem2mem_opcode_i,
    input  logic [2:0]        exmem2mem_funct3_i,
    input  logic [4:0]        exmem2mem_rd_i,
    input  logic [31:0]       exmem2mem_mem_addr_i,
    input  logic [31:0]       exmem2mem_store_data_i,
    input  logic [31:0]       exmem2mem_alu_data_i,
    output logic              mem2ex_stall_o,
    memu_bus_if.master        bus,
    output logic              mem2regs_wb_en_o,
    output logic [4:0]        mem2regs_rd_o,
    output logic [31:0]       mem2regs_rd_data_o,
    output logic              mem_misalign_o,
    output logic              mem_bus_err_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
    state_t      state, state_d;
    logic        is_load, is_store, f3_ok, mem_op, misal, alu_op, accept, done, timeout;
    logic [31:0] cnt;
    logic [4:0]  cap_rd;
    logic [2:0]  cap_f3;
    logic [1:0]  cap_off;
    logic        cap_st;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld_data, wdata_fmt;
    logic [3:0]  wstrb_fmt;
    logic        wb_d, req_d, we_d, mis_d, err_d;
    logic [4:0]  rd_d;
    logic [31:0] rd_data_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]  wstrb_d;
    assign is_load  = exmem2mem_opcode_i == 7'b0000011;
    assign is_store = exmem2mem_opcode_i == 7'b0100011;
    // loads: 000,001,010,100,101; stores: 000,001,010; anything else is a NOP
    assign f3_ok    = is_load ? (exmem2mem_funct3_i != 3'b011 && exmem2mem_funct3_i[2:1] != 2'b11)
                              : (is_store && !exmem2mem_funct3_i[2] && exmem2mem_funct3_i[1:0] != 2'b11);
    assign mem_op   = exmem2mem_valid_i && f3_ok;
    assign misal    = (exmem2mem_funct3_i[0] && exmem2mem_mem_addr_i[0])
                   || (exmem2mem_funct3_i[1] && exmem2mem_mem_addr_i[1:0] != 2'b00);
    assign alu_op   = exmem2mem_valid_i && !is_load && !is_store;
    assign accept   = state == IDLE && mem_op && !misal;
    assign done     = (state == REQ && bus.gnt && cap_st) || (state == RESP && bus.rvalid);
    assign timeout  = TIMEOUT_CYC != 0 && state != IDLE && cnt == TO_LAST;
    assign mem2ex_stall_o = state != IDLE || accept;
    assign wstrb_fmt = !is_store ? 4'b0000
                     : exmem2mem_funct3_i[1:0] == 2'b00 ? 4'b0001 << exmem2mem_mem_addr_i[1:0]
                     : exmem2mem_funct3_i[1:0] == 2'b01 ? 4'b0011 << exmem2mem_mem_addr_i[1:0]
                     : 4'b1111;
    assign wdata_fmt = exmem2mem_funct3_i[1:0] == 2'b00 ? {4{exmem2mem_store_data_i[7:0]}}
                     : exmem2mem_funct3_i[1:0] == 2'b01 ? {2{exmem2mem_store_data_i[15:0]}}
                     : exmem2mem_store_data_i;
    assign lb      = bus.rdata[{cap_off, 3'b000} +: 8];
    assign lh      = cap_off[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    assign ld_data = cap_f3[1:0] == 2'b00 ? {{24{lb[7] & ~cap_f3[2]}}, lb}
                   : cap_f3[1:0] == 2'b01 ? {{16{lh[15] & ~cap_f3[2]}}, lh}
                   : bus.rdata;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end
    // a granted store completes; otherwise the timeout beats a simultaneous load grant
    always_comb begin
        state_d = state == IDLE ? (accept ? REQ : IDLE)
                : (done || timeout) ? IDLE
                : (state == REQ && bus.gnt) ? RESP
                : state;
    end
    always_comb begin
        wb_d      = state == IDLE ? (alu_op && exmem2mem_wb_en_i && exmem2mem_rd_i != 5'd0)
                                  : (state == RESP && bus.rvalid && cap_rd != 5'd0);
        rd_d      = (state == IDLE && alu_op) ? exmem2mem_rd_i
                  : (state == RESP && bus.rvalid) ? cap_rd : mem2regs_rd_o;
        rd_data_d = (state == IDLE && alu_op) ? exmem2mem_alu_data_i
                  : (state == RESP && bus.rvalid) ? ld_data : mem2regs_rd_data_o;
        req_d     = state_d == REQ;
        we_d      = accept ? is_store : bus.we;
        addr_d    = accept ? {exmem2mem_mem_addr_i[ADDR_W-1:2], 2'b00} : bus.addr;
        wstrb_d   = accept ? wstrb_fmt : bus.wstrb;
        wdata_d   = accept ? wdata_fmt : bus.wdata;
        mis_d     = state == IDLE && mem_op && misal;
        err_d     = timeout && !done;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt                <= '0;
            cap_rd             <= '0;
            cap_f3             <= '0;
            cap_off            <= '0;
            cap_st             <= 1'b0;
            mem2regs_wb_en_o   <= 1'b0;
            mem2regs_rd_o      <= '0;
            mem2regs_rd_data_o <= '0;
            bus.req            <= 1'b0;
            bus.we             <= 1'b0;
            bus.addr           <= '0;
            bus.wstrb          <= '0;
            bus.wdata          <= '0;
            mem_misalign_o     <= 1'b0;
            mem_bus_err_o      <= 1'b0;
        end else begin
            cnt                <= state == IDLE ? '0 : cnt + 32'd1;
            if (accept) begin
                cap_rd  <= exmem2mem_rd_i;
                cap_f3  <= exmem2mem_funct3_i;
                cap_off <= exmem2mem_mem_addr_i[1:0];
                cap_st  <= is_store;
            end
            mem2regs_wb_en_o   <= wb_d;
            mem2regs_rd_o      <= rd_d;
            mem2regs_rd_data_o <= rd_data_d;
            bus.req            <= req_d;
            bus.we             <= we_d;
            bus.addr           <= addr_d;
            bus.wstrb          <= wstrb_d;
            bus.wdata          <= wdata_d;
            mem_misalign_o     <= mis_d;
            mem_bus_err_o      <= err_d;
        end
    end
endmodule
